lc3_controller: RTL and testbench
=================================

LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: complete_instr  in  1  instruction memory returned data this cycle.
REQ-004 SHALL have port: complete_data  in  1  data memory access finished this cycle.
REQ-005 SHALL have port: IR  in  16  instruction held in decode output, entering execute.
REQ-006 SHALL have port: IR_Exec  in  16  instruction held in execute output.
REQ-007 SHALL have port: psr  in  3  current NZP flags.
REQ-008 SHALL have outputs, each 1 bit: enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback, br_taken.
REQ-009 SHALL have outputs, each 1 bit: bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2.
REQ-010 SHALL have port: mem_state  out  2  0 = read, 1 = indirect address read, 2 = write, 3 = idle.

Function
REQ-011 SHALL use FSM states RUN, MEM_IND, MEM_RD, MEM_WR, CTRL_WAIT, encoded in the shared package.
REQ-012 SHALL use a 3-bit fill register, valid[2:0] for decode/execute/writeback, shifting 1 in per RUN cycle with complete_instr=1; the stage enable = RUN & valid bit.
REQ-013 In RUN with complete_instr=0: all five enables SHALL be 0 and the fill register SHALL hold.
REQ-014 In RUN, when IR_Exec[15:12] is LD/LDR (0010/0110): next state MEM_RD; ST/STR (0011/0111): MEM_WR; LDI/STI (1010/1011): MEM_IND.
REQ-015 In any MEM_* state: enable_updatePC, fetch, decode, execute SHALL be 0; mem_state = 1/0/2 for MEM_IND/MEM_RD/MEM_WR.
REQ-016 MEM_IND with complete_data=1 SHALL go to MEM_RD for LDI and to MEM_WR for STI.
REQ-017 MEM_RD with complete_data=1 SHALL go to RUN and assert enable_writeback for exactly that cycle.
REQ-018 MEM_WR with complete_data=1 SHALL go to RUN with enable_writeback=0.
REQ-019 A MEM_* state SHALL hold, outputs unchanged, while complete_data=0.
REQ-020 In RUN, when IR[15:12] is BR (0000) or JMP (1100): enable_updatePC and enable_fetch SHALL be 0 that cycle; next state CTRL_WAIT with 2-bit counter loaded to 2.
REQ-021 CTRL_WAIT SHALL decrement the counter each cycle; at count 0 it SHALL assert enable_updatePC for one cycle and set br_taken; next state RUN with valid cleared to 000.
REQ-022 br_taken for BR SHALL be ((IR_Exec[11:9] & psr) != 0); br_taken for JMP SHALL be 1; br_taken SHALL be 0 in all other cycles.
REQ-023 Priority within a cycle: memory-op detection (REQ-014) > control detection (REQ-020) > imem stall (REQ-013).
REQ-024 mem_state SHALL be 3 outside MEM_* states.
REQ-025 bypass_alu_1 SHALL be 1 when IR_Exec is ADD/AND/NOT/LEA and IR_Exec[11:9] == IR[8:6] and IR is ADD/AND/NOT/LDR/STR/JMP.
REQ-026 bypass_alu_2 SHALL be 1 when IR_Exec is ADD/AND/NOT/LEA, IR is ADD/AND with IR[5]=0, and IR_Exec[11:9] == IR[2:0].
REQ-027 bypass_mem_1/2 SHALL follow the same register compares as REQ-025/026 with IR_Exec a load (LD/LDR/LDI).
REQ-028 bypass outputs SHALL be combinational, gated to 0 unless state is RUN.

Reset
REQ-029 While rst=0: state RUN, valid=000, counter 0, all enables 0, br_taken 0, bypasses 0, mem_state 3.
REQ-030 First edge after rst release: enable_updatePC and enable_fetch SHALL be 1; decode, execute, writeback SHALL enable 1, 2, 3 cycles later (with complete_instr=1).
REQ-031 Reset asserted mid-MEM_* or CTRL_WAIT SHALL abort immediately to the REQ-029 values.

Structure
REQ-032 The opcode constants, FSM state encoding and mem_state codes SHALL live in shared package lc3_pkg.
REQ-033 The register-compare logic of REQ-025..028 SHALL be one sub-module, lc3_bypass_unit.

Verification
REQ-034 Reset release, complete_instr=1, IR=0x1042 -> enables rise in order updatePC/fetch, decode (+1), execute (+2), writeback (+3).
REQ-035 IR_Exec=0x2205 (LD), complete_data low 3 cycles -> mem_state=0 for 4 cycles, fetch enables 0, one-cycle writeback pulse, then RUN.
REQ-036 IR_Exec=0xA205 (LDI) -> mem_state 1 until complete_data, then 0 until complete_data, then 3; STI 0xB205 -> 1 then 2.
REQ-037 IR=0x0A03 (BRnp), psr=3'b001 -> fetch stalled 3 cycles, br_taken=1 with the enable_updatePC pulse, valid refilled; psr=3'b010 -> br_taken=0.
REQ-038 IR_Exec=0x1401 (ADD R2), IR=0x1682 (ADD R3,R2,R2) -> bypass_alu_1=1, bypass_alu_2=1; IR_Exec=0x6440 (LDR R2) -> bypass_mem_1=1, bypass_mem_2=1.
REQ-039 rst pulled low in MEM_RD -> same cycle all outputs to reset values, mem_state=3.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 pipeline controller.
//   - opcode constants (IR[15:12])
//   - controller FSM state encoding
//   - mem_state codes reported to the data-memory side
//   - small opcode classification helpers
package lc3_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    MEM_IND   = 3'd1,
    MEM_RD    = 3'd2,
    MEM_WR    = 3'd3,
    CTRL_WAIT = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IND   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  // Instructions whose result comes out of the ALU in execute.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_ST) ||
           (op == OP_STR) || (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  // First memory state for a load/store leaving execute.
  function automatic state_t mem_entry_state(input logic [3:0] op);
    if ((op == OP_LDI) || (op == OP_STI)) return MEM_IND;
    else if ((op == OP_ST) || (op == OP_STR)) return MEM_WR;
    else return MEM_RD;
  endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// Pipeline-side signal bundle of the LC-3 controller.
//   inputs : complete_instr, complete_data, IR, IR_Exec, psr
//   outputs: stage enables, br_taken, bypass selects, mem_state
// slave  = controller view, master = the pipeline/environment driving it.
interface lc3_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;

  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  modport slave (
    input  complete_instr, complete_data, IR, IR_Exec, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );

  modport master (
    output complete_instr, complete_data, IR, IR_Exec, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );
endinterface

// File: rtl/lc3_bypass_unit.sv
// Operand forwarding selects for the instruction entering execute.
//   run            : controller is in RUN (selects forced to 0 otherwise)
//   ir_op/sr1/sr2  : opcode and source fields of IR, ir_imm = IR[5]
//   ex_op/ex_dr    : opcode and destination field of IR_Exec
//   bypass_alu_*   : forward the execute-stage ALU result to source 1/2
//   bypass_mem_*   : forward the loaded memory value to source 1/2
module lc3_bypass_unit
  import lc3_pkg::*;
(
  input  logic       run,
  input  logic [3:0] ir_op,
  input  logic [2:0] ir_sr1,
  input  logic [2:0] ir_sr2,
  input  logic       ir_imm,
  input  logic [3:0] ex_op,
  input  logic [2:0] ex_dr,
  output logic       bypass_alu_1,
  output logic       bypass_alu_2,
  output logic       bypass_mem_1,
  output logic       bypass_mem_2
);

  logic [2:0] src_reg [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;
  logic [1:0] alu_fwd;
  logic [1:0] mem_fwd;
  logic       ex_alu;
  logic       ex_load;

  assign src_reg[0] = ir_sr1;
  assign src_reg[1] = ir_sr2;

  // SR1 is read by ALU ops, base-register memory ops and JMP; SR2 only by
  // ADD/AND in register mode (IR[5]=0 selects the register operand).
  assign src_used[0] = (ir_op == OP_ADD) || (ir_op == OP_AND) || (ir_op == OP_NOT) ||
                       (ir_op == OP_LDR) || (ir_op == OP_STR) || (ir_op == OP_JMP);
  assign src_used[1] = ((ir_op == OP_ADD) || (ir_op == OP_AND)) && !ir_imm;

  assign ex_alu  = is_alu_op(ex_op);
  assign ex_load = is_load_op(ex_op);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = run && src_used[gi] && (ex_dr == src_reg[gi]);
      assign alu_fwd[gi] = src_hit[gi] && ex_alu;
      assign mem_fwd[gi] = src_hit[gi] && ex_load;
    end
  endgenerate

  assign bypass_alu_1 = alu_fwd[0];
  assign bypass_alu_2 = alu_fwd[1];
  assign bypass_mem_1 = mem_fwd[0];
  assign bypass_mem_2 = mem_fwd[1];

endmodule

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: stage enables, memory-access sequencing,
// branch resolution stall and operand bypass selects.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : lc3_controller_if.slave (memory handshakes, IR/IR_Exec/psr in;
//         enables, br_taken, bypass selects, mem_state out)
module lc3_controller
  import lc3_pkg::*;
(
  input logic             clk,
  input logic             rst,
  lc3_controller_if.slave bus
);

  state_t     state_reg, state_next;
  logic [2:0] valid_reg, valid_next;   // decode/execute/writeback holds a real instruction
  logic [1:0] count_reg, count_next;

  logic [3:0] op_d;
  logic [3:0] op_x;
  logic       advance;
  logic       upd_c, fetch_c, dec_c, exe_c, wb_c, br_c;
  logic [1:0] ms_c;

  assign op_d = bus.IR[15:12];
  assign op_x = bus.IR_Exec[15:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      valid_reg <= 3'b000;
      count_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    advance    = 1'b0;
    upd_c      = 1'b0;
    fetch_c    = 1'b0;
    dec_c      = 1'b0;
    exe_c      = 1'b0;
    wb_c       = 1'b0;
    br_c       = 1'b0;
    ms_c       = MS_IDLE;

    case (state_reg)
      RUN: begin
        if (is_mem_op(op_x)) begin
          // The pipeline still steps this cycle (if imem delivered); the
          // load/store then finishes its access in the memory states.
          advance    = bus.complete_instr;
          state_next = mem_entry_state(op_x);
        end else if (is_ctrl_op(op_d)) begin
          // Let the BR/JMP move into execute but stop fetching down the
          // fall-through path until the target is known.
          dec_c      = valid_reg[0];
          exe_c      = valid_reg[1];
          wb_c       = valid_reg[2];
          count_next = 2'd2;
          state_next = CTRL_WAIT;
        end else begin
          advance = bus.complete_instr;
        end

        if (advance) begin
          upd_c      = 1'b1;
          fetch_c    = 1'b1;
          dec_c      = valid_reg[0];
          exe_c      = valid_reg[1];
          wb_c       = valid_reg[2];
          valid_next = {valid_reg[1:0], 1'b1};
        end
      end

      MEM_IND: begin
        ms_c = MS_IND;
        if (bus.complete_data)
          state_next = (op_x == OP_LDI) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        ms_c = MS_READ;
        if (bus.complete_data) begin
          wb_c       = 1'b1;
          state_next = RUN;
        end
      end

      MEM_WR: begin
        ms_c = MS_WRITE;
        if (bus.complete_data)
          state_next = RUN;
      end

      CTRL_WAIT: begin
        if (count_reg == 2'd0) begin
          upd_c = 1'b1;
          if (op_x == OP_BR)
            br_c = |(bus.IR_Exec[11:9] & bus.psr);
          else
            br_c = (op_x == OP_JMP);
          // Whatever was fetched behind the branch is discarded.
          valid_next = 3'b000;
          state_next = RUN;
        end else begin
          count_next = count_reg - 2'd1;
        end
      end

      default: state_next = RUN;
    endcase
  end

  // Outputs are also gated by rst so they drop in the same cycle reset
  // is asserted, independent of the clock.
  assign bus.enable_updatePC  = rst & upd_c;
  assign bus.enable_fetch     = rst & fetch_c;
  assign bus.enable_decode    = rst & dec_c;
  assign bus.enable_execute   = rst & exe_c;
  assign bus.enable_writeback = rst & wb_c;
  assign bus.br_taken         = rst & br_c;
  assign bus.mem_state        = rst ? ms_c : MS_IDLE;

  lc3_bypass_unit u_bypass (
    .run          (rst && (state_reg == RUN)),
    .ir_op        (op_d),
    .ir_sr1       (bus.IR[8:6]),
    .ir_sr2       (bus.IR[2:0]),
    .ir_imm       (bus.IR[5]),
    .ex_op        (op_x),
    .ex_dr        (bus.IR_Exec[11:9]),
    .bypass_alu_1 (bus.bypass_alu_1),
    .bypass_alu_2 (bus.bypass_alu_2),
    .bypass_mem_1 (bus.bypass_mem_1),
    .bypass_mem_2 (bus.bypass_mem_2)
  );

endmodule

// File: tb/tb_lc3_controller.sv
// Directed testbench for lc3_controller. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 more unit later.
module tb_lc3_controller;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  lc3_controller_if bus ();

  lc3_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // en = {updatePC, fetch, decode, execute, writeback}
  task automatic chk_ctl(input string tag, input logic [4:0] en, input logic br,
                         input logic [1:0] ms);
    logic [7:0] obs;
    logic [7:0] exp_v;
    obs   = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
             bus.enable_execute, bus.enable_writeback, bus.br_taken, bus.mem_state};
    exp_v = {en, br, ms};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed en/br/ms=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // exp_v = {alu_1, alu_2, mem_1, mem_2}
  task automatic chk_byp(input string tag, input logic [3:0] exp_v);
    logic [3:0] obs;
    obs = {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed bypass=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.IR      = 16'h1042;
    bus.IR_Exec = 16'h1042;
    bus.psr     = 3'b000;

    // reset state
    tick(); tick();
    chk_ctl("reset_idle", 5'b00000, 1'b0, 2'd3);
    chk_byp("reset_byp", 4'b0000);
    bus.complete_instr = 1'b1;
    #1 chk_ctl("reset_gates_imem", 5'b00000, 1'b0, 2'd3);

    // release: pipeline fills one stage per cycle
    tick(); rst = 1'b1;
    #1 chk_ctl("fill_c0", 5'b11000, 1'b0, 2'd3);
    tick(); #1 chk_ctl("fill_c1", 5'b11100, 1'b0, 2'd3);
    tick(); #1 chk_ctl("fill_c2", 5'b11110, 1'b0, 2'd3);
    tick(); #1 chk_ctl("fill_c3", 5'b11111, 1'b0, 2'd3);

    // imem stall holds the fill register
    tick(); bus.complete_instr = 1'b0;
    #1 chk_ctl("imem_stall0", 5'b00000, 1'b0, 2'd3);
    tick(); #1 chk_ctl("imem_stall1", 5'b00000, 1'b0, 2'd3);
    bus.complete_instr = 1'b1;
    #1 chk_ctl("imem_resume", 5'b11111, 1'b0, 2'd3);

    // LD with three wait cycles on data memory
    tick(); bus.IR_Exec = 16'h2205;
    #1 chk_ctl("ld_detect", 5'b11111, 1'b0, 2'd3);
    tick(); #1 chk_ctl("ld_wait0", 5'b00000, 1'b0, 2'd0);
    tick(); #1 chk_ctl("ld_wait1", 5'b00000, 1'b0, 2'd0);
    tick(); #1 chk_ctl("ld_wait2", 5'b00000, 1'b0, 2'd0);
    tick(); bus.complete_data = 1'b1;
    #1 chk_ctl("ld_done", 5'b00001, 1'b0, 2'd0);
    tick(); bus.complete_data = 1'b0; bus.IR_Exec = 16'h1042;
    #1 chk_ctl("ld_run", 5'b11111, 1'b0, 2'd3);

    // LDI: indirect read then read
    tick(); bus.IR_Exec = 16'hA205;
    #1 chk_ctl("ldi_detect", 5'b11111, 1'b0, 2'd3);
    tick(); #1 chk_ctl("ldi_ind_wait", 5'b00000, 1'b0, 2'd1);
    bus.complete_data = 1'b1;
    #1 chk_ctl("ldi_ind_done", 5'b00000, 1'b0, 2'd1);
    tick(); bus.complete_data = 1'b0;
    #1 chk_ctl("ldi_rd_wait", 5'b00000, 1'b0, 2'd0);
    bus.complete_data = 1'b1;
    #1 chk_ctl("ldi_rd_done", 5'b00001, 1'b0, 2'd0);
    tick(); bus.complete_data = 1'b0; bus.IR_Exec = 16'h1042;
    #1 chk_ctl("ldi_run", 5'b11111, 1'b0, 2'd3);

    // STI: indirect read then write, no writeback
    tick(); bus.IR_Exec = 16'hB205;
    #1 chk_ctl("sti_detect", 5'b11111, 1'b0, 2'd3);
    tick(); bus.complete_data = 1'b1;
    #1 chk_ctl("sti_ind_done", 5'b00000, 1'b0, 2'd1);
    tick(); bus.complete_data = 1'b0;
    #1 chk_ctl("sti_wr_wait", 5'b00000, 1'b0, 2'd2);
    bus.complete_data = 1'b1;
    #1 chk_ctl("sti_wr_done", 5'b00000, 1'b0, 2'd2);
    tick(); bus.complete_data = 1'b0; bus.IR_Exec = 16'h1042;
    #1 chk_ctl("sti_run", 5'b11111, 1'b0, 2'd3);

    // BRnp taken (psr = p)
    tick(); bus.IR = 16'h0A03; bus.psr = 3'b001;
    #1 chk_ctl("br_detect", 5'b00111, 1'b0, 2'd3);
    tick(); bus.IR = 16'h1042; bus.IR_Exec = 16'h0A03;
    #1 chk_ctl("br_wait2", 5'b00000, 1'b0, 2'd3);
    chk_byp("br_byp_gated", 4'b0000);
    tick(); #1 chk_ctl("br_wait1", 5'b00000, 1'b0, 2'd3);
    tick(); #1 chk_ctl("br_pulse", 5'b10000, 1'b1, 2'd3);
    tick(); bus.IR_Exec = 16'h1042;
    #1 chk_ctl("br_refill0", 5'b11000, 1'b0, 2'd3);
    tick(); #1 chk_ctl("br_refill1", 5'b11100, 1'b0, 2'd3);
    tick(); #1 chk_ctl("br_refill2", 5'b11110, 1'b0, 2'd3);
    tick(); #1 chk_ctl("br_refill3", 5'b11111, 1'b0, 2'd3);

    // BRnp not taken (psr = z)
    tick(); bus.IR = 16'h0A03; bus.psr = 3'b010;
    #1 chk_ctl("brn_detect", 5'b00111, 1'b0, 2'd3);
    tick(); bus.IR = 16'h1042; bus.IR_Exec = 16'h0A03;
    tick(); tick();
    #1 chk_ctl("brn_pulse", 5'b10000, 1'b0, 2'd3);
    tick(); bus.IR_Exec = 16'h1042;
    #1 chk_ctl("brn_refill0", 5'b11000, 1'b0, 2'd3);

    // JMP is always taken
    tick(); bus.IR = 16'hC1C0;
    #1 chk_ctl("jmp_detect", 5'b00100, 1'b0, 2'd3);
    tick(); bus.IR = 16'h1042; bus.IR_Exec = 16'hC1C0;
    tick(); tick();
    #1 chk_ctl("jmp_pulse", 5'b10000, 1'b1, 2'd3);
    tick(); bus.IR_Exec = 16'h1042;
    #1 chk_ctl("jmp_refill0", 5'b11000, 1'b0, 2'd3);
    tick(); tick(); tick();
    #1 chk_ctl("jmp_refill3", 5'b11111, 1'b0, 2'd3);

    // bypass selects
    chk_byp("byp_none", 4'b0000);
    bus.IR = 16'h1682; bus.IR_Exec = 16'h1401;
    #1 chk_byp("byp_alu", 4'b1100);
    bus.IR = 16'h16A2;
    #1 chk_byp("byp_alu_imm", 4'b1000);
    bus.IR = 16'h1682; bus.IR_Exec = 16'h6440;
    #1 chk_byp("byp_mem", 4'b0011);
    tick();
    #1 chk_byp("byp_gated_mem", 4'b0000);
    chk_ctl("ldr_wait", 5'b00000, 1'b0, 2'd0);

    // reset asserted while in MEM_RD
    rst = 1'b0;
    #1 chk_ctl("rst_in_mem", 5'b00000, 1'b0, 2'd3);
    chk_byp("rst_in_mem_byp", 4'b0000);
    tick(); #1 chk_ctl("rst_hold", 5'b00000, 1'b0, 2'd3);
    bus.IR = 16'h1042; bus.IR_Exec = 16'h1042; rst = 1'b1;
    #1 chk_ctl("rst_release", 5'b11000, 1'b0, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
